booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Parametrised sequential signed Booth multiplier, successor to the fixed 4-bit unit. It has WIDTH-bit two's-complement operands, a 2*WIDTH-bit exact product, and valid/ready handshakes on both input and output. It sits between operand-producing datapath stages and the consumer, and tolerates output back-pressure.

Parameters:
WIDTH, 8, operand width in bits. Must be even and >= 4. Product width is 2*WIDTH.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH  signed multiplicand
b  in  WIDTH  signed multiplier
out_valid  out  1  product valid, held until accepted
out_ready  in  1  consumer accepts product
p  out  2*WIDTH  signed product a*b
busy  out  1  high in CALC or DONE

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; p=0, out_valid=0, busy=0, in_ready=1.
  - Internal accumulator, shifted operands, iteration counter and q_-1 all cleared.
  - Reset mid-operation aborts the operation with no output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid at an edge, capture a and b (sign-extended internally), clear acc, counter and q_-1, go to CALC.
  - CALC: one Booth step per cycle; in_ready=0. After the step with counter==ITER-1, load p with the final acc and go to DONE.
  - DONE: out_valid=1; p is stable. On out_ready at an edge, go to IDLE and set out_valid=0. Without out_ready, hold indefinitely.
- ITER: WIDTH for radix-2; WIDTH/2 with the optional feature.
- Latency:
  - Operands are accepted at edge k. out_valid rises at edge k+ITER.
  - The earliest next accept is one cycle after the output handshake, because in_ready is asserted only in IDLE.
  - Throughput is one product per ITER+2 cycles.
- Radix-2 step:
  - Examine {b_shift[0], q_-1}: 01 adds the multiplicand, 10 subtracts it, 00/11 leave acc unchanged.
  - Then shift the multiplicand left by 1, arithmetic-shift the multiplier right by 1, and set q_-1 to the old b_shift[0].
- Widths:
  - Multiplicand and acc are held at 2*WIDTH+2 bits, sign-extended, so negating the most negative value cannot overflow.
  - p is the low 2*WIDTH bits. The product is exact for all inputs, including min*min = 2^(2*WIDTH-2).
- Ignored inputs:
  - in_valid while not in IDLE has no effect; operands are not queued.
  - Changes to a and b after acceptance do not affect the result.
- p keeps the last product after leaving DONE, until the next DONE load or reset.
- There are no $display calls or other simulation-only side effects in the RTL.

Optional Feature:
BOOTH_RADIX4_EN
- Defined:
  - Radix-4 modified Booth with ITER=WIDTH/2.
  - Examine {b_shift[1:0], q_-1} to select a digit in {0, ±1, ±2}*multiplicand.
  - Shift the multiplicand left by 2 and the multiplier right (arithmetic) by 2 per step; q_-1 takes the old b_shift[1].
- Not defined: radix-2 as above, ITER=WIDTH.
- Ports and handshake are identical in both builds; only latency differs.

Decomposition:
- Package booth_pkg holds:
  - state encoding (IDLE, CALC, DONE);
  - a function computing ITER from WIDTH and the macro;
  - the radix-4 digit encoding constants.
- One sub-module is natural: booth_recoder. It is combinational: takes the 2-bit (radix-2) or 3-bit (radix-4) window plus the extended multiplicand, and returns the signed addend.
- The FSM, counter and registers stay in booth_mult_seq.

Test Plan:
- WIDTH=8, radix-2: a=7, b=-3, out_ready=1 -> in_ready drops at the next edge; out_valid at accept+8; p=-21 (16'hFFEB); IDLE one cycle later.
- WIDTH=8 extremes: (-128)*(-128) -> p=16384; (-128)*127 -> p=-16256; 0*(-1) -> p=0.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid and p held constant, in_ready=0, new in_valid ignored. out_ready=1 -> handshake, then next operands accepted.
- Reset mid-CALC: rst_n=0 at step 3 -> next cycle p=0, out_valid=0, in_ready=1, busy=0. A fresh 5*5 gives p=25.
- BOOTH_RADIX4_EN, WIDTH=8: a=-7, b=6 -> out_valid at accept+4, p=-42. Random 1000 pairs for WIDTH=4, 8 and 16 in both builds match a*b.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// Radix is selected by BOOTH_RADIX4_EN (radix-4 when defined, radix-2 otherwise).
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Radix-4 digit set; the multiplicand is scaled by one of these per step
  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } digit_e;

`ifdef BOOTH_RADIX4_EN
  localparam int STEP  = 2;
  localparam int WIN_W = 3;
`else
  localparam int STEP  = 1;
  localparam int WIN_W = 2;
`endif

  function automatic int booth_iter(input int width);
    return width / STEP;
  endfunction

  function automatic digit_e booth_digit(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return DIG_POS1;
      3'b011:         return DIG_POS2;
      3'b100:         return DIG_NEG2;
      3'b101, 3'b110: return DIG_NEG1;
      default:        return DIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: maps the multiplier window to the signed addend.
// Window is 3 bits under BOOTH_RADIX4_EN, 2 bits otherwise.
module booth_recoder
  import booth_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic [WIN_W-1:0] window,
  input  logic [AW-1:0]    mcand,
  output logic [AW-1:0]    addend
);

  always_comb begin
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case (booth_digit(window))
      DIG_POS1: addend = mcand;
      DIG_POS2: addend = mcand << 1;
      DIG_NEG1: addend = -mcand;
      DIG_NEG2: addend = -(mcand << 1);
      default:  addend = '0;
    endcase
`else
    case (window)
      2'b01:   addend = mcand;
      2'b10:   addend = -mcand;
      default: addend = '0;
    endcase
`endif
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier with valid/ready on operands and product.
// BOOTH_RADIX4_EN selects radix-4 (WIDTH/2 steps) instead of radix-2 (WIDTH steps).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | in_ready high, waiting for an operand pair
//   ST_CALC | one Booth step per cycle
//   ST_DONE | product on p, out_valid high until accepted
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int AW   = 2*WIDTH + 2;
  localparam int ITER = booth_iter(WIDTH);
  localparam int CW   = $clog2(ITER);

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;

  logic [WIN_W-1:0]     window;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        acc_sum;

  assign window  = {mplier_q[STEP-1:0], qm1_q};
  assign acc_sum = acc_q + addend;

  booth_recoder #(.AW(AW)) u_recoder (
    .window (window),
    .mcand  (mcand_q),
    .addend (addend)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    qm1_d       = qm1_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Multiplicand is sign-extended so negating the most negative value stays exact
          mcand_d    = {{(AW-WIDTH){a[WIDTH-1]}}, a};
          mplier_d   = b;
          acc_d      = '0;
          qm1_d      = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = $signed(mplier_q) >>> STEP;
        qm1_d    = mplier_q[STEP-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER-1)) begin
          p_d         = acc_sum[2*WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      qm1_q       <= 1'b0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      qm1_q       <= qm1_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomized self-checking bench for booth_mult_seq against a plain a*b reference.
// Expected latency follows BOOTH_RADIX4_EN (WIDTH/2 steps) or radix-2 (WIDTH steps).
module tb_booth_mult_seq;

  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int EXP_LAT = W / 2;
`else
  localparam int EXP_LAT = W;
`endif

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic                out_valid;
  logic                out_ready;
  logic [2*W-1:0]      p;
  logic                busy;

  int total = 0;
  int bad   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    int unsigned r;
    r = $urandom;
    a = r[W-1:0];
    b = r[2*W-1:W];
  endtask

  // One full transaction; hold = cycles of back-pressure after out_valid rises
  task automatic mult(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb,
                      input int hold);
    longint ea, eb;
    logic signed [2*W-1:0] e;
    int cyc;
    ea = ta;
    eb = tb;
    e  = (2*W)'(ea * eb);
    chk("in_ready_idle", in_ready, 1);
    a = ta;
    b = tb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    rand_ops();
    chk("in_ready_drop", in_ready, 0);
    chk("busy_calc", busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 4*W) begin
      tick();
      if ($urandom_range(0, 1) == 1) rand_ops();
      in_valid = ($urandom_range(0, 3) == 0);
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", cyc, EXP_LAT);
    chk("product", $signed(p), e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      rand_ops();
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_p", $signed(p), e);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy_low", busy, 0);
    chk("p_kept", $signed(p), e);
  endtask

  initial begin
    logic signed [W-1:0] ra, rb;
    int unsigned r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    chk("rst_p", p, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    mult(8'sd7, -8'sd3, 0);
    mult(-8'sd128, -8'sd128, 0);
    mult(-8'sd128, 8'sd127, 0);
    mult(8'sd0, -8'sd1, 0);
    mult(-8'sd7, 8'sd6, 0);
    mult(8'sd127, 8'sd127, 5);
    mult(-8'sd1, -8'sd1, 2);

    // Abort mid-calculation: nothing must come out
    a = 8'sd11;
    b = -8'sd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_p", p, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2 * W) begin
      tick();
      chk("abort_quiet", out_valid, 0);
    end
    mult(8'sd5, 8'sd5, 0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom;
      ra = r[W-1:0];
      rb = r[2*W-1:W];
      mult(ra, rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
